// File: rtl/muldiv_pkg.sv
// Shared constants for the M-extension mul/div unit.
// funct3 encodings and FSM state type.
package muldiv_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/muldiv_unit_div_iter.sv
// One restoring-division step on unsigned magnitudes.
// The dividend shifts out of quo_i into the partial remainder.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    rem_sh = {rem_i, quo_i[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_i};
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// RV M-extension execution unit: pipelined multiply,
// iterative restoring divide, valid/ready handshake.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] rd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_out,
  output logic             busy
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(XLEN + MUL_STAGES + 1);
  localparam int PW = 2 * XLEN + 2;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic [XLEN:0]    ma_q, ma_d, mb_q, mb_d;
  logic [PW-1:0]    pipe_q [MUL_STAGES];
  logic [PW-1:0]    pipe_d [MUL_STAGES];
  logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d, res_q, res_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;

  logic [XLEN-1:0]  rem_n, quo_n;
  logic [PW-1:0]    prod;
  logic             accept, sgn, a_neg, b_neg, ovf;
  logic             a_mx, b_mx;
  logic [XLEN-1:0]  a_abs, b_abs;
  logic             unused_prod;

  div_iter #(.XLEN(XLEN)) u_iter (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_n),
    .quo_o (quo_n)
  );

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;

  assign sgn   = ~funct3[0];
  assign a_neg = sgn & op_a[XLEN-1];
  assign b_neg = sgn & op_b[XLEN-1];
  assign a_abs = a_neg ? -op_a : op_a;
  assign b_abs = b_neg ? -op_b : op_b;
  assign ovf   = sgn & (op_a == MIN_NEG) & (op_b == '1);
  assign a_mx  = ((funct3 == F3_MULH) || (funct3 == F3_MULHSU))
               & op_a[XLEN-1];
  assign b_mx  = (funct3 == F3_MULH) & op_b[XLEN-1];

  // Sign-extend to full product width so the low PW bits are exact.
  assign prod = {{(XLEN+1){ma_q[XLEN]}}, ma_q}
              * {{(XLEN+1){mb_q[XLEN]}}, mb_q};
  assign unused_prod = ^pipe_q[MUL_STAGES-1][PW-1:2*XLEN];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    pipe_d  = pipe_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d = funct3;
          rd_d = rd_in;
          if (!funct3[2]) begin
            ma_d    = {a_mx, op_a};
            mb_d    = {b_mx, op_b};
            cnt_d   = '0;
            state_d = MUL;
          end else if (op_b == '0) begin
            res_d   = funct3[1] ? op_a : '1;
            state_d = DONE;
          end else if (ovf) begin
            res_d   = funct3[1] ? '0 : MIN_NEG;
            state_d = DONE;
          end else begin
            quo_d   = a_abs;
            rem_d   = '0;
            dvs_d   = b_abs;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = CW'(XLEN - 1);
            state_d = DIV;
          end
        end
      end
      MUL: begin
        pipe_d[0] = prod;
        for (int i = 1; i < MUL_STAGES; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
        if (cnt_q == CW'(MUL_STAGES - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DIV: begin
        rem_d = rem_n;
        quo_d = quo_n;
        if (cnt_q == '0) begin
          if (f3_q[1]) begin
            res_d = rneg_q ? -rem_n : rem_n;
          end else begin
            res_d = qneg_q ? -quo_n : quo_n;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        pipe_q[i] <= '0;
      end
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      pipe_q  <= pipe_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  always_comb begin
    result = '0;
    rd_out = '0;
    if (state_q == DONE) begin
      rd_out = rd_q;
      if (f3_q[2]) begin
        result = res_q;
      end else if (f3_q == F3_MUL) begin
        result = pipe_q[MUL_STAGES-1][XLEN-1:0];
      end else begin
        result = pipe_q[MUL_STAGES-1][2*XLEN-1:XLEN];
      end
    end
  end
endmodule
